// File: rtl/scr1_ahb_arb2.sv
// scr1_ahb_arb2 : two-master to one-slave AHB-Lite arbiter.
// m0 is the IMEM bridge and m1 is the DMEM bridge. The address phase and the
// data phase are tracked separately, so one master's data phase can overlap
// the other master's address phase without adding a bubble.
// Optional feature macro: SCR1_AHB_ARB_RR_EN
//   defined   -> round-robin between the masters when both request
//   undefined -> fixed priority, m1 over m0 (m0 may starve under constant m1 traffic)
`ifndef SCR1_AHB_WIDTH
`define SCR1_AHB_WIDTH 32
`endif

module scr1_ahb_arb2 (
  input  logic                       clk,
  input  logic                       rst_n,
  // master 0 (IMEM bridge)
  input  logic [1:0]                 m0_htrans_i,
  input  logic [`SCR1_AHB_WIDTH-1:0] m0_haddr_i,
  input  logic                       m0_hwrite_i,
  input  logic [2:0]                 m0_hsize_i,
  input  logic [2:0]                 m0_hburst_i,
  input  logic [3:0]                 m0_hprot_i,
  input  logic                       m0_hmastlock_i,
  input  logic [`SCR1_AHB_WIDTH-1:0] m0_hwdata_i,
  output logic                       m0_hready_o,
  output logic [`SCR1_AHB_WIDTH-1:0] m0_hrdata_o,
  output logic                       m0_hresp_o,
  // master 1 (DMEM bridge)
  input  logic [1:0]                 m1_htrans_i,
  input  logic [`SCR1_AHB_WIDTH-1:0] m1_haddr_i,
  input  logic                       m1_hwrite_i,
  input  logic [2:0]                 m1_hsize_i,
  input  logic [2:0]                 m1_hburst_i,
  input  logic [3:0]                 m1_hprot_i,
  input  logic                       m1_hmastlock_i,
  input  logic [`SCR1_AHB_WIDTH-1:0] m1_hwdata_i,
  output logic                       m1_hready_o,
  output logic [`SCR1_AHB_WIDTH-1:0] m1_hrdata_o,
  output logic                       m1_hresp_o,
  // shared slave port
  output logic [1:0]                 s_htrans_o,
  output logic [`SCR1_AHB_WIDTH-1:0] s_haddr_o,
  output logic                       s_hwrite_o,
  output logic [2:0]                 s_hsize_o,
  output logic [2:0]                 s_hburst_o,
  output logic [3:0]                 s_hprot_o,
  output logic                       s_hmastlock_o,
  output logic [`SCR1_AHB_WIDTH-1:0] s_hwdata_o,
  input  logic                       s_hready_i,
  input  logic [`SCR1_AHB_WIDTH-1:0] s_hrdata_i,
  input  logic                       s_hresp_i
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic       HRESP_OKAY  = 1'b0;

  logic req0_s;
  logic req1_s;
  logic hold_s;
  logic gnt_s;
  logic gnt_q;
  logic lock_q;
  logic lock_d;
  logic dph_vld_q;
  logic dph_vld_d;
  logic dph_own_q;
  logic dph_own_d;
  logic s_act_s;
`ifdef SCR1_AHB_ARB_RR_EN
  logic rr_last_q;
  logic rr_last_d;
`endif

  // SEQ and BUSY are treated as ordinary requests, same as NONSEQ
  assign req0_s  = (m0_htrans_i != HTRANS_IDLE);
  assign req1_s  = (m1_htrans_i != HTRANS_IDLE);
  assign s_act_s = (s_htrans_o  != HTRANS_IDLE);

  // Address grant: frozen during a stalled address phase or a locked sequence
  always_comb begin
    gnt_s  = gnt_q;
    hold_s = lock_q | (gnt_q ? m1_hmastlock_i : m0_hmastlock_i);
    if (hold_s) begin
      gnt_s = gnt_q;
    end else if (req0_s & req1_s) begin
`ifdef SCR1_AHB_ARB_RR_EN
      gnt_s = ~rr_last_q;
`else
      gnt_s = 1'b1;
`endif
    end else if (req1_s) begin
      gnt_s = 1'b1;
    end else if (req0_s) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = gnt_q;
    end
  end

  // Address-phase mux from the granted master
  always_comb begin
    s_htrans_o    = m0_htrans_i;
    s_haddr_o     = m0_haddr_i;
    s_hwrite_o    = m0_hwrite_i;
    s_hsize_o     = m0_hsize_i;
    s_hburst_o    = m0_hburst_i;
    s_hprot_o     = m0_hprot_i;
    s_hmastlock_o = m0_hmastlock_i;
    if (gnt_s) begin
      s_htrans_o    = m1_htrans_i;
      s_haddr_o     = m1_haddr_i;
      s_hwrite_o    = m1_hwrite_i;
      s_hsize_o     = m1_hsize_i;
      s_hburst_o    = m1_hburst_i;
      s_hprot_o     = m1_hprot_i;
      s_hmastlock_o = m1_hmastlock_i;
    end else begin
      s_htrans_o    = m0_htrans_i;
      s_haddr_o     = m0_haddr_i;
      s_hwrite_o    = m0_hwrite_i;
      s_hsize_o     = m0_hsize_i;
      s_hburst_o    = m0_hburst_i;
      s_hprot_o     = m0_hprot_i;
      s_hmastlock_o = m0_hmastlock_i;
    end
  end

  // Write data follows whichever master owns the data phase
  always_comb begin
    s_hwdata_o = m0_hwdata_i;
    if (dph_own_q) begin
      s_hwdata_o = m1_hwdata_i;
    end else begin
      s_hwdata_o = m0_hwdata_i;
    end
  end

  // Next state: address-stall lock, data-phase owner and round-robin history
  always_comb begin
    lock_d    = lock_q;
    dph_vld_d = dph_vld_q;
    dph_own_d = dph_own_q;
`ifdef SCR1_AHB_ARB_RR_EN
    rr_last_d = rr_last_q;
`endif
    if (s_hready_i) begin
      lock_d    = 1'b0;
      dph_vld_d = s_act_s;
      dph_own_d = gnt_s;
`ifdef SCR1_AHB_ARB_RR_EN
      if (s_act_s) begin
        rr_last_d = gnt_s;
      end else begin
        rr_last_d = rr_last_q;
      end
`endif
    end else if (s_act_s) begin
      lock_d = 1'b1;
    end else begin
      lock_d = lock_q;
    end
  end

  // Per-master ready/response: data-phase owner first, then grant, then idle
  always_comb begin
    m0_hready_o = 1'b0;
    m1_hready_o = 1'b0;
    m0_hresp_o  = HRESP_OKAY;
    m1_hresp_o  = HRESP_OKAY;
    if (dph_vld_q & ~dph_own_q) begin
      m0_hready_o = s_hready_i;
      m0_hresp_o  = s_hresp_i;
    end else if (~gnt_s) begin
      m0_hready_o = s_hready_i;
    end else begin
      m0_hready_o = ~req0_s;
    end
    if (dph_vld_q & dph_own_q) begin
      m1_hready_o = s_hready_i;
      m1_hresp_o  = s_hresp_i;
    end else if (gnt_s) begin
      m1_hready_o = s_hready_i;
    end else begin
      m1_hready_o = ~req1_s;
    end
  end

  assign m0_hrdata_o = s_hrdata_i;
  assign m1_hrdata_o = s_hrdata_i;

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= 1'b0;
      lock_q    <= 1'b0;
      dph_vld_q <= 1'b0;
      dph_own_q <= 1'b0;
`ifdef SCR1_AHB_ARB_RR_EN
      rr_last_q <= 1'b1;
`endif
    end else begin
      gnt_q     <= gnt_s;
      lock_q    <= lock_d;
      dph_vld_q <= dph_vld_d;
      dph_own_q <= dph_own_d;
`ifdef SCR1_AHB_ARB_RR_EN
      rr_last_q <= rr_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_scr1_ahb_arb2.sv
// Directed bench for scr1_ahb_arb2: single master, contention, address stall
// with lock, error routing, hmastlock sequences and priority / round-robin.
module tb_scr1_ahb_arb2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [31:0] m0_haddr, m1_haddr;
  logic        m0_hwrite, m1_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, m0_hburst, m1_hburst;
  logic [3:0]  m0_hprot, m1_hprot;
  logic        m0_hmastlock, m1_hmastlock;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hresp, m1_hresp;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic        s_hmastlock;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic [31:0] s_hrdata;
  logic        s_hresp;

  int n_chk = 0;
  int n_err = 0;

  scr1_ahb_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_htrans_i(m0_htrans), .m0_haddr_i(m0_haddr), .m0_hwrite_i(m0_hwrite),
    .m0_hsize_i(m0_hsize), .m0_hburst_i(m0_hburst), .m0_hprot_i(m0_hprot),
    .m0_hmastlock_i(m0_hmastlock), .m0_hwdata_i(m0_hwdata),
    .m0_hready_o(m0_hready), .m0_hrdata_o(m0_hrdata), .m0_hresp_o(m0_hresp),
    .m1_htrans_i(m1_htrans), .m1_haddr_i(m1_haddr), .m1_hwrite_i(m1_hwrite),
    .m1_hsize_i(m1_hsize), .m1_hburst_i(m1_hburst), .m1_hprot_i(m1_hprot),
    .m1_hmastlock_i(m1_hmastlock), .m1_hwdata_i(m1_hwdata),
    .m1_hready_o(m1_hready), .m1_hrdata_o(m1_hrdata), .m1_hresp_o(m1_hresp),
    .s_htrans_o(s_htrans), .s_haddr_o(s_haddr), .s_hwrite_o(s_hwrite),
    .s_hsize_o(s_hsize), .s_hburst_o(s_hburst), .s_hprot_o(s_hprot),
    .s_hmastlock_o(s_hmastlock), .s_hwdata_o(s_hwdata),
    .s_hready_i(s_hready), .s_hrdata_i(s_hrdata), .s_hresp_i(s_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    m0_htrans = IDLE; m0_haddr = 32'h0; m0_hwrite = 1'b0; m0_hsize = 3'd2;
    m0_hburst = 3'd0; m0_hprot = 4'h3; m0_hmastlock = 1'b0;
    m1_htrans = IDLE; m1_haddr = 32'h0; m1_hwrite = 1'b0; m1_hsize = 3'd2;
    m1_hburst = 3'd0; m1_hprot = 4'h1; m1_hmastlock = 1'b0;
    s_hready = 1'b1; s_hresp = 1'b0;
  endtask

  // drive-then-sample helpers: inputs change 1 after posedge, outputs checked at negedge
  task automatic to_sample();
    @(negedge clk);
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    m0_hwdata = 32'h0; m1_hwdata = 32'h0; s_hrdata = 32'h0;
    rst_n = 1'b0;
    #2;
    // reset state
    chk("rst_m0_hready", m0_hready, 32'd1);
    chk("rst_m1_hready", m1_hready, 32'd1);
    chk("rst_s_htrans", s_htrans, 32'(IDLE));
    chk("rst_m0_hresp", m0_hresp, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // 1: lone m0 read at 0x100
    m0_htrans = NONSEQ; m0_haddr = 32'h100;
    to_sample();
    chk("t1_s_haddr", s_haddr, 32'h100);
    chk("t1_s_htrans", s_htrans, 32'(NONSEQ));
    chk("t1_m0_hready", m0_hready, 32'd1);
    next_cycle();
    m0_htrans = IDLE; s_hrdata = 32'hDEAD0001;
    to_sample();
    chk("t1_m0_hrdata", m0_hrdata, 32'hDEAD0001);
    chk("t1_dph_m0_hready", m0_hready, 32'd1);
    chk("t1_idle_s_htrans", s_htrans, 32'(IDLE));
    next_cycle();

    // 2: simultaneous requests, m1 wins, m0 follows with overlap
    m0_htrans = NONSEQ; m0_haddr = 32'h100;
    m1_htrans = NONSEQ; m1_haddr = 32'h200;
    to_sample();
    chk("t2_s_haddr_m1", s_haddr, 32'h200);
    chk("t2_m0_stall", m0_hready, 32'd0);
    chk("t2_m1_hready", m1_hready, 32'd1);
    next_cycle();
    m1_htrans = IDLE; s_hrdata = 32'hBEEF0200;
    to_sample();
    chk("t2_s_haddr_m0", s_haddr, 32'h100);
    chk("t2_m0_hready", m0_hready, 32'd1);
    chk("t2_m1_dph_hready", m1_hready, 32'd1);
    chk("t2_m1_hrdata", m1_hrdata, 32'hBEEF0200);
    next_cycle();
    m0_htrans = IDLE;
    to_sample();
    chk("t2_m0_dph_hready", m0_hready, 32'd1);
    next_cycle();

    // 3: m1 write held by slave wait states, m0 arrives mid-stall
    m1_htrans = NONSEQ; m1_haddr = 32'h200; m1_hwrite = 1'b1; s_hready = 1'b0;
    m0_hwdata = 32'h11111111;
    to_sample();
    chk("t3_s_haddr_c0", s_haddr, 32'h200);
    chk("t3_s_hwrite", s_hwrite, 32'd1);
    chk("t3_m1_hready_c0", m1_hready, 32'd0);
    next_cycle();
    m0_htrans = NONSEQ; m0_haddr = 32'h300;
    to_sample();
    chk("t3_s_haddr_c1", s_haddr, 32'h200);
    chk("t3_m0_hready_c1", m0_hready, 32'd0);
    next_cycle();
    to_sample();
    chk("t3_s_haddr_c2", s_haddr, 32'h200);
    chk("t3_m1_hready_c2", m1_hready, 32'd0);
    next_cycle();
    s_hready = 1'b1;
    to_sample();
    chk("t3_s_haddr_acc", s_haddr, 32'h200);
    chk("t3_m1_hready_acc", m1_hready, 32'd1);
    chk("t3_m0_hready_acc", m0_hready, 32'd0);
    next_cycle();
    m1_htrans = IDLE; m1_hwrite = 1'b0; m1_hwdata = 32'hCAFE0200;
    to_sample();
    chk("t3_s_hwdata_m1", s_hwdata, 32'hCAFE0200);
    chk("t3_s_haddr_m0", s_haddr, 32'h300);
    chk("t3_m0_hready", m0_hready, 32'd1);
    next_cycle();
    m0_htrans = IDLE;
    to_sample();
    chk("t3_s_hwdata_m0", s_hwdata, 32'h11111111);
    next_cycle();

    // 4: two-cycle ERROR on m1 data phase, m0 address issued in first ERR cycle
    m1_htrans = NONSEQ; m1_haddr = 32'h204;
    to_sample();
    chk("t4_s_haddr", s_haddr, 32'h204);
    next_cycle();
    m1_htrans = IDLE; m0_htrans = NONSEQ; m0_haddr = 32'h400;
    s_hresp = 1'b1; s_hready = 1'b0;
    to_sample();
    chk("t4_m1_hresp_c0", m1_hresp, 32'd1);
    chk("t4_m0_hresp_c0", m0_hresp, 32'd0);
    chk("t4_m1_hready_c0", m1_hready, 32'd0);
    chk("t4_s_haddr_pass", s_haddr, 32'h400);
    next_cycle();
    s_hready = 1'b1;
    to_sample();
    chk("t4_m1_hresp_c1", m1_hresp, 32'd1);
    chk("t4_m0_hresp_c1", m0_hresp, 32'd0);
    chk("t4_m1_hready_c1", m1_hready, 32'd1);
    chk("t4_s_haddr_c1", s_haddr, 32'h400);
    next_cycle();
    m0_htrans = IDLE; s_hresp = 1'b0;
    to_sample();
    chk("t4_m0_hresp_dph", m0_hresp, 32'd0);
    chk("t4_m1_hresp_end", m1_hresp, 32'd0);
    next_cycle();

    // 5: locked sequences hold the grant against the other master
    m1_htrans = NONSEQ; m1_haddr = 32'h500; m1_hmastlock = 1'b1;
    m0_htrans = NONSEQ; m0_haddr = 32'h600;
    to_sample();
    chk("t5_s_haddr_l0", s_haddr, 32'h500);
    chk("t5_s_hmastlock", s_hmastlock, 32'd1);
    chk("t5_m0_stall_l0", m0_hready, 32'd0);
    next_cycle();
    m1_haddr = 32'h504;
    to_sample();
    chk("t5_s_haddr_l1", s_haddr, 32'h504);
    chk("t5_m0_stall_l1", m0_hready, 32'd0);
    next_cycle();
    m1_htrans = IDLE; m1_hmastlock = 1'b0; m0_hmastlock = 1'b1;
    to_sample();
    chk("t5_s_haddr_m0", s_haddr, 32'h600);
    chk("t5_m0_hready", m0_hready, 32'd1);
    next_cycle();
    m0_haddr = 32'h604; m1_htrans = NONSEQ; m1_haddr = 32'h700;
    to_sample();
    chk("t5_s_haddr_m0lock", s_haddr, 32'h604);
    chk("t5_m1_stall", m1_hready, 32'd0);
    next_cycle();
    m0_htrans = IDLE; m0_hmastlock = 1'b0;
    to_sample();
    chk("t5_s_haddr_m1", s_haddr, 32'h700);
    chk("t5_m1_hready", m1_hready, 32'd1);
    next_cycle();
    m1_htrans = IDLE;
    to_sample();
    chk("t5_idle_s_htrans", s_htrans, 32'(IDLE));
    next_cycle();

    // 6: both request continuously
    m0_htrans = NONSEQ; m0_haddr = 32'h800;
    m1_htrans = NONSEQ; m1_haddr = 32'h900;
`ifdef SCR1_AHB_ARB_RR_EN
    to_sample();
    chk("t6_rr_c0", s_haddr, 32'h800);
    chk("t6_rr_m0_hready", m0_hready, 32'd1);
    next_cycle();
    to_sample();
    chk("t6_rr_c1", s_haddr, 32'h900);
    next_cycle();
    to_sample();
    chk("t6_rr_c2", s_haddr, 32'h800);
    next_cycle();
    to_sample();
    chk("t6_rr_c3", s_haddr, 32'h900);
    next_cycle();
`else
    to_sample();
    chk("t6_fp_c0", s_haddr, 32'h900);
    chk("t6_fp_m0_c0", m0_hready, 32'd0);
    next_cycle();
    to_sample();
    chk("t6_fp_c1", s_haddr, 32'h900);
    chk("t6_fp_m0_c1", m0_hready, 32'd0);
    next_cycle();
    to_sample();
    chk("t6_fp_c2", s_haddr, 32'h900);
    chk("t6_fp_m0_c2", m0_hready, 32'd0);
    next_cycle();
`endif

    // reset in the middle of traffic abandons tracking
    idle_all();
    rst_n = 1'b0;
    to_sample();
    chk("rst2_s_htrans", s_htrans, 32'(IDLE));
    chk("rst2_m0_hready", m0_hready, 32'd1);
    chk("rst2_m1_hresp", m1_hresp, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
